// File: rtl/router_pkg.sv
// Shared definitions for the router packet protocol: header field layout,
// payload limits and the packet sink FSM encoding.
package router_pkg;

    localparam int LEN_MSB     = 7;
    localparam int LEN_LSB     = 2;
    localparam int ADDR_MSB    = 1;
    localparam int ADDR_LSB    = 0;
    localparam int MAX_PAYLOAD = 63;

    // Wide enough to hold MAX_PAYLOAD + 1 (payload plus parity byte).
    localparam int ISSUE_W = $clog2(MAX_PAYLOAD + 2);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HDR  = 2'd2;
    localparam logic [1:0] ST_BODY = 2'd3;

    function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// 8-bit XOR accumulator: load seeds the running value, accum folds in a byte,
// mismatch compares the running value against the presented byte.
module router_parity_acc (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       accum,
    input  logic [7:0] din,
    output logic [7:0] acc,
    output logic       mismatch
);

    logic [7:0] acc_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_reg <= 8'h00;
        end else if (load) begin
            acc_reg <= din;
        end else if (accum) begin
            acc_reg <= acc_reg ^ din;
        end
    end

    assign acc      = acc_reg;
    assign mismatch = (acc_reg != din);

endmodule

// File: rtl/router_pkt_sink.sv
// Consumer for one router output port: reads header/payload/parity frames from
// the port FIFO, streams payload bytes and reports per-packet status.
module router_pkt_sink
    import router_pkg::*;
#(
    parameter int PORT_ID     = 2,
    parameter int START_DELAY = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             valid_out,
    input  logic [7:0]       data_out,
    output logic             read_enb,
    output logic [7:0]       byte_data,
    output logic             byte_valid,
    output logic             pkt_done,
    output logic [5:0]       pkt_len,
    output logic             pkt_parity_err,
    output logic             pkt_addr_err,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);

    logic [1:0]         state_reg;
    logic [1:0]         state_next;
    logic [4:0]         dly_cnt_reg;
    logic               hdr_issued_reg;
    logic [ISSUE_W-1:0] issued_reg;
    logic [ISSUE_W-1:0] remaining_reg;
    logic [ISSUE_W-1:0] captured_reg;
    logic [ISSUE_W-1:0] captured_inc;
    logic               rd_q_reg;
    logic               addr_err_q_reg;
    logic [5:0]         len_q_reg;

    logic [7:0]         byte_data_reg;
    logic               byte_valid_reg;
    logic               pkt_done_reg;
    logic [5:0]         pkt_len_reg;
    logic               parity_err_reg;
    logic               addr_err_reg;
    logic [CNT_W-1:0]   pkt_count_reg;
    logic [CNT_W-1:0]   err_count_reg;

    logic               hdr_cap;
    logic               body_cap;
    logic               last_cap;
    logic               parity_mismatch;
    logic [7:0]         acc_value;

    assign hdr_cap      = rd_q_reg && (state_reg == ST_HDR);
    assign body_cap     = rd_q_reg && (state_reg == ST_BODY);
    assign captured_inc = captured_reg + 1'b1;
    assign last_cap     = body_cap && (captured_inc == remaining_reg);

    // Combinational on valid_out so a FIFO going empty stops reads in the same cycle.
    always_comb begin
        read_enb = 1'b0;
        if (state_reg == ST_HDR) begin
            read_enb = valid_out && !hdr_issued_reg;
        end else if (state_reg == ST_BODY) begin
            read_enb = valid_out && (issued_reg < remaining_reg);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (valid_out && enable) begin
                    state_next = (START_DELAY > 0) ? ST_WAIT : ST_HDR;
                end
            end
            ST_WAIT: begin
                if (dly_cnt_reg == 5'(START_DELAY)) begin
                    state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                if (hdr_cap) begin
                    state_next = ST_BODY;
                end
            end
            default: begin
                if (last_cap) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    router_parity_acc u_parity (
        .clock    (clock),
        .reset    (reset),
        .load     (hdr_cap),
        .accum    (body_cap && !last_cap),
        .din      (data_out),
        .acc      (acc_value),
        .mismatch (parity_mismatch)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            dly_cnt_reg    <= 5'd0;
            hdr_issued_reg <= 1'b0;
            issued_reg     <= '0;
            remaining_reg  <= '0;
            captured_reg   <= '0;
            rd_q_reg       <= 1'b0;
            addr_err_q_reg <= 1'b0;
            len_q_reg      <= 6'd0;
            byte_data_reg  <= 8'h00;
            byte_valid_reg <= 1'b0;
            pkt_done_reg   <= 1'b0;
            pkt_len_reg    <= 6'd0;
            parity_err_reg <= 1'b0;
            addr_err_reg   <= 1'b0;
            pkt_count_reg  <= '0;
            err_count_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            rd_q_reg       <= read_enb;
            byte_valid_reg <= 1'b0;
            pkt_done_reg   <= 1'b0;

            if (state_reg == ST_IDLE) begin
                dly_cnt_reg    <= 5'd1;
                hdr_issued_reg <= 1'b0;
            end else if (state_reg == ST_WAIT) begin
                dly_cnt_reg <= dly_cnt_reg + 5'd1;
            end

            if ((state_reg == ST_HDR) && read_enb) begin
                hdr_issued_reg <= 1'b1;
            end

            if (hdr_cap) begin
                issued_reg     <= '0;
                captured_reg   <= '0;
                remaining_reg  <= ISSUE_W'(hdr_len(data_out)) + 1'b1;
                len_q_reg      <= hdr_len(data_out);
                addr_err_q_reg <= (data_out[ADDR_MSB:ADDR_LSB] != 2'(PORT_ID));
            end

            if ((state_reg == ST_BODY) && read_enb) begin
                issued_reg <= issued_reg + 1'b1;
            end

            if (body_cap) begin
                captured_reg <= captured_inc;
                if (!last_cap) begin
                    byte_data_reg  <= data_out;
                    byte_valid_reg <= 1'b1;
                end
            end

            // The final capture is the parity byte: acc_value holds header ^ payload.
            if (last_cap) begin
                pkt_done_reg   <= 1'b1;
                pkt_len_reg    <= len_q_reg;
                parity_err_reg <= parity_mismatch;
                addr_err_reg   <= addr_err_q_reg;
                if (pkt_count_reg != '1) begin
                    pkt_count_reg <= pkt_count_reg + 1'b1;
                end
                if ((parity_mismatch || addr_err_q_reg) && (err_count_reg != '1)) begin
                    err_count_reg <= err_count_reg + 1'b1;
                end
            end
        end
    end

    assign byte_data      = byte_data_reg;
    assign byte_valid     = byte_valid_reg;
    assign pkt_done       = pkt_done_reg;
    assign pkt_len        = pkt_len_reg;
    assign pkt_parity_err = parity_err_reg;
    assign pkt_addr_err   = addr_err_reg;
    assign pkt_count      = pkt_count_reg;
    assign err_count      = err_count_reg;

    logic unused_acc;
    assign unused_acc = ^acc_value;

endmodule

// File: tb/tb_router_pkt_sink.sv
// Directed bench for router_pkt_sink: two instances (START_DELAY 0 and 5) each
// fed by a small FIFO model; payload strobes are collected by a monitor.
module tb_router_pkt_sink;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        valid_out      [2];
    logic [7:0]  data_out       [2];
    logic        read_enb       [2];
    logic [7:0]  byte_data      [2];
    logic        byte_valid     [2];
    logic        pkt_done       [2];
    logic [5:0]  pkt_len        [2];
    logic        pkt_parity_err [2];
    logic        pkt_addr_err   [2];
    logic [15:0] pkt_count      [2];
    logic [15:0] err_count      [2];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        router_pkt_sink #(
            .PORT_ID     (2),
            .START_DELAY (gi * 5),
            .CNT_W       (16)
        ) u_dut (
            .clock          (clock),
            .reset          (reset),
            .enable         (enable),
            .valid_out      (valid_out[gi]),
            .data_out       (data_out[gi]),
            .read_enb       (read_enb[gi]),
            .byte_data      (byte_data[gi]),
            .byte_valid     (byte_valid[gi]),
            .pkt_done       (pkt_done[gi]),
            .pkt_len        (pkt_len[gi]),
            .pkt_parity_err (pkt_parity_err[gi]),
            .pkt_addr_err   (pkt_addr_err[gi]),
            .pkt_count      (pkt_count[gi]),
            .err_count      (err_count[gi])
        );
    end

    // FIFO models: data_out is valid the cycle after a read strobe.
    logic [7:0] fmem [2][256];
    int         wr_ptr [2] = '{0, 0};
    int         rd_ptr [2] = '{0, 0};
    logic       gate   [2] = '{1'b1, 1'b1};

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            valid_out[k] = (rd_ptr[k] != wr_ptr[k]) && gate[k];
        end
    end

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (read_enb[k] === 1'b1) begin
                data_out[k] <= fmem[k][rd_ptr[k] % 256];
                rd_ptr[k]   <= rd_ptr[k] + 1;
            end
        end
    end

    logic [7:0] cap    [2][128];
    int         bv_cnt [2] = '{0, 0};

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (byte_valid[k] === 1'b1) begin
                cap[k][bv_cnt[k] % 128] <= byte_data[k];
                bv_cnt[k]               <= bv_cnt[k] + 1;
            end
        end
    end

    logic [7:0] pay [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] b);
        fmem[k][wr_ptr[k] % 256] = b;
        wr_ptr[k]++;
    endtask

    task automatic push_frame(input int k, input logic [7:0] hdr, input int n, input logic [7:0] flip);
        logic [7:0] par;
        par = hdr;
        push(k, hdr);
        for (int i = 0; i < n; i++) begin
            push(k, pay[i]);
            par = par ^ pay[i];
        end
        push(k, par ^ flip);
    endtask

    task automatic wait_read(input int k, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (read_enb[k] !== 1'b1 && n < 40);
    endtask

    task automatic wait_done(input int k, input string tag);
        int n;
        n = 0;
        while (n < 300) begin
            @(negedge clock);
            n++;
            if (pkt_done[k] === 1'b1) break;
        end
        check({tag, " pkt_done"}, 32'(pkt_done[k]), 32'd1);
    endtask

    task automatic wait_bytes(input int k, input int target, input string tag);
        int n;
        n = 0;
        while (bv_cnt[k] < target && n < 300) begin
            @(negedge clock);
            n++;
        end
        check({tag, " bytes reached"}, 32'(bv_cnt[k] >= target), 32'd1);
    endtask

    task automatic check_bytes(input int k, input int base, input int n, input string tag);
        check({tag, " strobe count"}, 32'(bv_cnt[k] - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s byte%0d", tag, i), 32'(cap[k][(base + i) % 128]), 32'(pay[i]));
        end
    endtask

    task automatic check_status(input int k, input string tag, input int len, input int perr,
                                input int aerr, input int pcnt, input int ecnt);
        check({tag, " pkt_len"},        32'(pkt_len[k]),        32'(len));
        check({tag, " pkt_parity_err"}, 32'(pkt_parity_err[k]), 32'(perr));
        check({tag, " pkt_addr_err"},   32'(pkt_addr_err[k]),   32'(aerr));
        check({tag, " pkt_count"},      32'(pkt_count[k]),      32'(pcnt));
        check({tag, " err_count"},      32'(err_count[k]),      32'(ecnt));
    endtask

    task automatic check_reset_state(input int k, input string tag);
        check({tag, " read_enb"},   32'(read_enb[k]),   32'd0);
        check({tag, " byte_valid"}, 32'(byte_valid[k]), 32'd0);
        check({tag, " pkt_done"},   32'(pkt_done[k]),   32'd0);
        check({tag, " byte_data"},  32'(byte_data[k]),  32'h00);
        check_status(k, tag, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int         n;
        int         base;
        logic [7:0] par;

        reset  = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_state(0, "reset0");
        check_reset_state(1, "reset1");
        reset = 1'b0;
        @(negedge clock);

        // Good packet, header 0x22: length 8, address 2.
        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
        base = bv_cnt[0];
        push_frame(0, 8'h22, 8, 8'h00);
        wait_read(0, n);
        check("t1 hdr latency", 32'(n), 32'd1);
        wait_done(0, "t1");
        check_status(0, "t1", 8, 0, 0, 1, 0);
        check_bytes(0, base, 8, "t1");
        @(negedge clock);
        check("t1 pkt_done one-shot", 32'(pkt_done[0]), 32'd0);
        check("t1 pkt_len held", 32'(pkt_len[0]), 32'd8);

        // Same frame with a corrupted parity byte.
        base = bv_cnt[0];
        push_frame(0, 8'h22, 8, 8'h01);
        wait_done(0, "t2");
        check_status(0, "t2", 8, 1, 0, 2, 1);
        check_bytes(0, base, 8, "t2");

        // Header 0x15: length 5, address 1 on port 2.
        base = bv_cnt[0];
        push_frame(0, 8'h15, 5, 8'h00);
        wait_done(0, "t3");
        check_status(0, "t3", 5, 0, 1, 3, 2);
        check_bytes(0, base, 5, "t3");
        check("t3 drained valid_out", 32'(valid_out[0]), 32'd0);

        // START_DELAY=5 instance, header 0x0E (length 3), stall after byte 2.
        for (int i = 0; i < 3; i++) pay[i] = 8'($urandom);
        base = bv_cnt[1];
        push(1, 8'h0E);
        push(1, pay[0]);
        push(1, pay[1]);
        wait_read(1, n);
        check("t4 hdr latency", 32'(n), 32'd6);
        wait_bytes(1, base + 2, "t4");
        gate[1] = 1'b0;
        par = 8'h0E ^ pay[0] ^ pay[1] ^ pay[2];
        push(1, pay[2]);
        push(1, par);
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            check($sformatf("t4 stall read_enb%0d", j), 32'(read_enb[1]), 32'd0);
        end
        gate[1] = 1'b1;
        wait_done(1, "t4");
        check_status(1, "t4", 3, 0, 0, 1, 0);
        check_bytes(1, base, 3, "t4");

        // Length-0 frame held off by enable, then released.
        enable = 1'b0;
        base = bv_cnt[0];
        push_frame(0, 8'h02, 0, 8'h00);
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            check($sformatf("t5 enable-low read_enb%0d", j), 32'(read_enb[0]), 32'd0);
        end
        enable = 1'b1;
        wait_done(0, "t5");
        check_status(0, "t5", 0, 0, 0, 4, 2);
        check_bytes(0, base, 0, "t5");

        // Reset in the middle of a length-8 packet, then a clean 0x16 frame.
        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
        base = bv_cnt[0];
        push_frame(0, 8'h22, 8, 8'h00);
        wait_bytes(0, base + 4, "t6");
        reset = 1'b1;
        @(negedge clock);
        wr_ptr[0] = rd_ptr[0];
        check_reset_state(0, "t6 reset");
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
        base = bv_cnt[0];
        push_frame(0, 8'h16, 5, 8'h00);
        wait_done(0, "t6");
        check_status(0, "t6", 5, 0, 0, 1, 0);
        check_bytes(0, base, 5, "t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
